// File: rtl/mux5_2_rr_arbiter_if.sv
// Lane/handshake bundle between five lane producers, the round-robin
// arbiter and the single downstream consumer.
interface mux5_2_rr_arbiter_if #(
  parameter int N = 5,
  parameter int W = 2
);
  logic [N-1:0]   req;
  logic [N*W-1:0] a;
  logic [N-1:0]   gnt;
  logic [2:0]     sel;
  logic [W-1:0]   y;
  logic           y_valid;
  logic           y_ready;

  // Producer/consumer side: drives requests, lane data and ready.
  modport master (
    output req, a, y_ready,
    input  gnt, sel, y, y_valid
  );

  // Arbiter side.
  modport slave (
    input  req, a, y_ready,
    output gnt, sel, y, y_valid
  );
endinterface

// File: rtl/mux5_2_rr_arbiter.sv
// Round-robin arbiter wrapped around a 5:1 x 2-bit mux. The winning lane is
// captured into a one-word output register and offered downstream over
// valid/ready. A new word is loaded in the same cycle the old one drains,
// giving 1 word/cycle throughput.

// Plain 5:1 mux; any select of 5 or above (the idle code) yields zero.
module mux5_2 #(
  parameter int W = 2
) (
  input  logic [5*W-1:0] a,
  input  logic [2:0]     sel,
  output logic [W-1:0]   y
);
  // Select one lane, zero for the idle code and unused encodings.
  always_comb begin
    // NOTE: y is assigned on every path (via the default arm); a missing
    // assignment on any path would infer a latch.
    unique case (sel)
      3'd0:    y = a[0*W +: W];
      3'd1:    y = a[1*W +: W];
      3'd2:    y = a[2*W +: W];
      3'd3:    y = a[3*W +: W];
      3'd4:    y = a[4*W +: W];
      default: y = '0;
    endcase
  end
endmodule

module mux5_2_rr_arbiter #(
  parameter int N = 5,
  parameter int W = 2
) (
  input  logic                clk,
  input  logic                rst,
  mux5_2_rr_arbiter_if.slave  bus
);
  localparam logic [2:0] SEL_IDLE  = 3'd5;
  localparam logic [2:0] LAST_INIT = 3'(N - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t         state;
  logic [2:0]     last;
  logic [W-1:0]   y_q;
  logic           y_valid_q;

  logic           load;
  logic           has_win;
  logic [2:0]     win_idx;
  logic [2:0]     sel_c;
  logic [N-1:0]   gnt_c;
  logic [W-1:0]   mux_y;

  // Lane reached k steps after base in the circular scan order.
  function automatic logic [2:0] lane_after(logic [2:0] base, int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    return 3'(s % N);
  endfunction

  // The output register can take a word when empty, or when the held word drains now.
  assign load = (state == EMPTY) || (state == FULL && bus.y_ready);

  // Round-robin winner search starting just after the last granted lane.
  always_comb begin
    has_win = 1'b0;
    win_idx = '0;
    if (!rst && load && |bus.req) begin
      // Scan from the far end so the nearest requesting lane is written last and wins.
      for (int k = N; k >= 1; k--) begin
        if (bus.req[lane_after(last, k)]) begin
          has_win = 1'b1;
          win_idx = lane_after(last, k);
        end
      end
    end
  end

  assign sel_c = has_win ? win_idx : SEL_IDLE;
  assign gnt_c = has_win ? (N'(1) << win_idx) : '0;

  mux5_2 #(.W(W)) u_mux (
    .a   (bus.a),
    .sel (sel_c),
    .y   (mux_y)
  );

  // Handshake FSM with registered output word, valid flag and grant pointer.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state     <= EMPTY;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      last      <= LAST_INIT;
    end else if (has_win) begin
      state     <= FULL;
      y_q       <= mux_y;
      y_valid_q <= 1'b1;
      last      <= win_idx;
    end else if (state == FULL && bus.y_ready) begin
      state     <= EMPTY;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end
  end

  assign bus.gnt     = gnt_c;
  assign bus.sel     = sel_c;
  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
endmodule
